// File: rtl/rgb_pwm_periph.sv
// rgb_pwm_periph -- memory-mapped three-channel PWM LED controller.
//
// Register block at BASE_ADDR (16-byte aligned), word select bus_addr[3:2]:
//   0 DUTY   [7:0] R, [15:8] G, [23:16] B duty (R/W)
//   1 CTRL   [0] EN, [1] LED, [15:8] PRESCALE (R/W)
//   2 STATUS [7:0] pwm_cnt (RO), [8] WRAP sticky (write 1 clears)
//   3 reserved (reads 0, writes ignored)
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   bus_addr/wdata/wmask  store/load address, data and byte enables
//   bus_we, bus_re        single-cycle store / load strobes
//   bus_rdata, bus_rvalid load response, one cycle after a hit load
//   RGB_R/G/B             active-low PWM LED drives
//   LED                   active-high static LED drive (CTRL.LED)
module rgb_pwm_periph #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_2000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] bus_addr,
  input  logic [31:0] bus_wdata,
  input  logic [3:0]  bus_wmask,
  input  logic        bus_we,
  input  logic        bus_re,
  output logic [31:0] bus_rdata,
  output logic        bus_rvalid,
  output logic        RGB_R,
  output logic        RGB_G,
  output logic        RGB_B,
  output logic        LED
);

  typedef enum logic [1:0] {
    SEL_DUTY   = 2'd0,
    SEL_CTRL   = 2'd1,
    SEL_STATUS = 2'd2,
    SEL_RSVD   = 2'd3
  } reg_sel_e;

  logic [23:0] r_duty;
  logic        r_en;
  logic        r_led;
  logic [7:0]  r_prescale;
  logic [7:0]  r_pcnt;
  logic [7:0]  r_pwm_cnt;
  logic        r_wrap;
  logic [7:0]  r_sh_r, r_sh_g, r_sh_b;
  logic [2:0]  r_on;
  logic [31:0] r_rdata;
  logic        r_rvalid;

  logic        w_hit;
  reg_sel_e    w_sel;
  logic        w_wr_duty, w_wr_ctrl, w_wr_status;
  logic        w_tick, w_wrap, w_wrap_clr;
  logic [2:0]  w_on;
  logic [31:0] w_rd_val;

  assign w_hit       = (bus_addr[31:4] == BASE_ADDR[31:4]);
  assign w_sel       = reg_sel_e'(bus_addr[3:2]);
  assign w_wr_duty   = bus_we & w_hit & (w_sel == SEL_DUTY);
  assign w_wr_ctrl   = bus_we & w_hit & (w_sel == SEL_CTRL);
  assign w_wr_status = bus_we & w_hit & (w_sel == SEL_STATUS);
  assign w_wrap_clr  = w_wr_status & bus_wmask[1] & bus_wdata[8];

  // >= rather than == so a PRESCALE lowered below the running pcnt
  // terminates the prescale cycle immediately instead of waiting 256 counts.
  assign w_tick = r_en & (r_pcnt >= r_prescale);
  assign w_wrap = w_tick & (r_pwm_cnt == 8'hFF);

  assign w_on[0] = r_en & (r_pwm_cnt < r_sh_r);
  assign w_on[1] = r_en & (r_pwm_cnt < r_sh_g);
  assign w_on[2] = r_en & (r_pwm_cnt < r_sh_b);

  // Read mux sees pre-store values, so a same-cycle load+store returns old data.
  always_comb begin
    w_rd_val = '0;
    case (w_sel)
      SEL_DUTY:   w_rd_val = {8'h00, r_duty};
      SEL_CTRL:   w_rd_val = {16'h0000, r_prescale, 6'b000000, r_led, r_en};
      SEL_STATUS: w_rd_val = {23'd0, r_wrap, r_pwm_cnt};
      default:    w_rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_duty     <= '0;
      r_en       <= 1'b0;
      r_led      <= 1'b0;
      r_prescale <= '0;
      r_pcnt     <= '0;
      r_pwm_cnt  <= '0;
      r_wrap     <= 1'b0;
      r_sh_r     <= '0;
      r_sh_g     <= '0;
      r_sh_b     <= '0;
      r_on       <= '0;
      r_rdata    <= '0;
      r_rvalid   <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < 3; i++) begin
        if (w_wr_duty && bus_wmask[i]) r_duty[8*i +: 8] <= bus_wdata[8*i +: 8];
      end
      if (w_wr_ctrl && bus_wmask[0]) begin
        r_en  <= bus_wdata[0];
        r_led <= bus_wdata[1];
      end
      if (w_wr_ctrl && bus_wmask[1]) r_prescale <= bus_wdata[15:8];

      if (!r_en) begin
        r_pcnt    <= '0;
        r_pwm_cnt <= '0;
      end else if (w_tick) begin
        r_pcnt    <= '0;
        r_pwm_cnt <= r_pwm_cnt + 8'd1;
      end else begin
        r_pcnt    <= r_pcnt + 8'd1;
      end

      // Shadows track DUTY while idle so enabling starts with current duties.
      if (!r_en || w_wrap) begin
        r_sh_r <= r_duty[7:0];
        r_sh_g <= r_duty[15:8];
        r_sh_b <= r_duty[23:16];
      end

      // Set wins over a same-cycle clear.
      if (w_wrap)          r_wrap <= 1'b1;
      else if (w_wrap_clr) r_wrap <= 1'b0;

      r_on     <= w_on;
      r_rvalid <= bus_re & w_hit;
      r_rdata  <= (bus_re & w_hit) ? w_rd_val : '0;
    end
  end

  assign RGB_R      = ~r_on[0];
  assign RGB_G      = ~r_on[1];
  assign RGB_B      = ~r_on[2];
  assign LED        = r_led;
  assign bus_rdata  = r_rdata;
  assign bus_rvalid = r_rvalid;

endmodule

// File: tb/tb_rgb_pwm_periph.sv
// tb_rgb_pwm_periph -- directed plus randomized checks for rgb_pwm_periph.
// Expected values come from a register-level model (byte arrays, CTRL fields)
// and from the rule "low cycles per period = duty * (PRESCALE+1)".
module tb_rgb_pwm_periph;

  localparam logic [31:0] BASE = 32'h0000_2000;
  localparam logic [31:0] A_DUTY = BASE + 32'h0;
  localparam logic [31:0] A_CTRL = BASE + 32'h4;
  localparam logic [31:0] A_STAT = BASE + 32'h8;
  localparam logic [31:0] A_RSVD = BASE + 32'hC;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wmask;
  logic        bus_we;
  logic        bus_re;
  logic [31:0] bus_rdata;
  logic        bus_rvalid;
  logic        RGB_R, RGB_G, RGB_B, LED;

  int n_assert = 0;
  int n_fail   = 0;

  // Register model
  logic [7:0] m_duty [3];
  logic       m_en, m_led;
  logic [7:0] m_pre;

  rgb_pwm_periph #(.BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wmask(bus_wmask),
    .bus_we(bus_we), .bus_re(bus_re),
    .bus_rdata(bus_rdata), .bus_rvalid(bus_rvalid),
    .RGB_R(RGB_R), .RGB_G(RGB_G), .RGB_B(RGB_B), .LED(LED)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // All bus tasks are entered and left on a falling edge.
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    bus_addr = a; bus_wdata = d; bus_wmask = m; bus_we = 1'b1;
    @(negedge clk);
    bus_we = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic v);
    bus_addr = a; bus_re = 1'b1;
    @(negedge clk);
    v = bus_rvalid; d = bus_rdata;
    bus_re = 1'b0;
  endtask

  task automatic model_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    if (a == A_DUTY) begin
      for (int i = 0; i < 3; i++) if (m[i]) m_duty[i] = d[8*i +: 8];
    end else if (a == A_CTRL) begin
      if (m[0]) begin m_en = d[0]; m_led = d[1]; end
      if (m[1]) m_pre = d[15:8];
    end
  endtask

  function automatic logic [31:0] model_duty();
    return {8'h00, m_duty[2], m_duty[1], m_duty[0]};
  endfunction

  function automatic logic [31:0] model_ctrl();
    return {16'h0000, m_pre, 6'b000000, m_led, m_en};
  endfunction

  task automatic count_low(input int n, output int lr, output int lg, output int lb);
    lr = 0; lg = 0; lb = 0;
    repeat (n) begin
      @(negedge clk);
      if (!RGB_R) lr++;
      if (!RGB_G) lg++;
      if (!RGB_B) lb++;
    end
  endtask

  // Bounded wait for RGB_R to reach a level; ok=0 on timeout.
  task automatic wait_r(input logic lvl, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (RGB_R === lvl) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  initial begin
    logic [31:0] d, d2, a, wd;
    logic        v;
    logic [3:0]  m;
    int          lr, lg, lb, run, p;
    logic [7:0]  dr, dg, db;
    bit          ok;

    rst_n = 1'b0; bus_addr = '0; bus_wdata = '0; bus_wmask = '0;
    bus_we = 1'b0; bus_re = 1'b0;
    for (int i = 0; i < 3; i++) m_duty[i] = 8'h00;
    m_en = 1'b0; m_led = 1'b0; m_pre = 8'h00;
    #1;
    check("rst_pins", {29'd0, RGB_R, RGB_G, RGB_B}, 32'h7);
    check("rst_led", {31'd0, LED}, 32'h0);
    check("rst_rvalid", {31'd0, bus_rvalid}, 32'h0);
    check("rst_rdata", bus_rdata, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    rd(A_DUTY, d, v); check("rst_duty", d, 32'h0);
    rd(A_CTRL, d, v); check("rst_ctrl", d, 32'h0);
    rd(A_STAT, d, v); check("rst_status", d, 32'h0);

    // Fixed three-channel duty pattern, PRESCALE=0
    wr(A_DUTY, 32'h0040_80FF, 4'hF); model_wr(A_DUTY, 32'h0040_80FF, 4'hF);
    wr(A_CTRL, 32'h0000_0001, 4'hF); model_wr(A_CTRL, 32'h0000_0001, 4'hF);
    repeat (512) @(negedge clk);
    count_low(256, lr, lg, lb);
    check("pwm_r_ff", lr, m_duty[0]);
    check("pwm_g_80", lg, m_duty[1]);
    check("pwm_b_40", lb, m_duty[2]);

    // Randomized duties/prescale, including the 0 and 255 corners
    for (int it = 0; it < 6; it++) begin
      dr = 8'($urandom_range(0, 255));
      dg = 8'($urandom_range(0, 255));
      db = 8'($urandom_range(0, 255));
      if (it == 0) begin dr = 8'd0; dg = 8'd255; db = 8'd1; end
      p = $urandom_range(0, 1);
      wd = {8'h00, db, dg, dr};
      wr(A_CTRL, 32'h0, 4'hF);
      wr(A_DUTY, wd, 4'hF); model_wr(A_DUTY, wd, 4'hF);
      wr(A_CTRL, {16'h0, 8'(p), 8'h01}, 4'hF); model_wr(A_CTRL, {16'h0, 8'(p), 8'h01}, 4'hF);
      repeat (512 * (p + 1)) @(negedge clk);
      count_low(256 * (p + 1), lr, lg, lb);
      check("rnd_pwm_r", lr, 32'(dr) * 32'(p + 1));
      check("rnd_pwm_g", lg, 32'(dg) * 32'(p + 1));
      check("rnd_pwm_b", lb, 32'(db) * 32'(p + 1));
    end

    // Mid-period duty change: current period keeps old duty
    wr(A_CTRL, 32'h0, 4'hF);
    wr(A_DUTY, 32'h0000_0080, 4'hF);
    wr(A_CTRL, 32'h0000_0001, 4'hF);
    wait_r(1'b1, ok); check("mid_wait_hi", {31'd0, ok}, 32'h1);
    wait_r(1'b0, ok); check("mid_wait_lo", {31'd0, ok}, 32'h1);
    run = 1;
    repeat (63) begin @(negedge clk); if (!RGB_R) run++; end
    bus_addr = A_DUTY; bus_wdata = 32'h0000_0010; bus_wmask = 4'b0001; bus_we = 1'b1;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      bus_we = 1'b0;
      if (!RGB_R) run++; else break;
    end
    check("mid_cur_period", run, 32'd128);
    wait_r(1'b0, ok); check("mid_wait_lo2", {31'd0, ok}, 32'h1);
    run = 0;
    for (int i = 0; i < 600; i++) begin
      if (RGB_R) break;
      run++;
      @(negedge clk);
    end
    check("mid_next_period", run, 32'd16);

    // PRESCALE=3 and WRAP flag
    wr(A_CTRL, 32'h0, 4'hF);
    wr(A_DUTY, 32'h0000_0021, 4'hF);
    wr(A_STAT, 32'h0000_0100, 4'b0010);
    rd(A_STAT, d, v); check("wrap_cleared_idle", d, 32'h0);
    wr(A_CTRL, 32'h0000_0301, 4'hF);
    rd(A_STAT, d, v); check("wrap_before", {31'd0, d[8]}, 32'h0);
    repeat (1100) @(negedge clk);
    rd(A_STAT, d, v); check("wrap_set", {31'd0, d[8]}, 32'h1);
    wr(A_STAT, 32'h0000_0100, 4'b0010);
    rd(A_STAT, d, v); check("wrap_w1c", {31'd0, d[8]}, 32'h0);
    rd(A_STAT, d, v);
    repeat (15) @(negedge clk);
    rd(A_STAT, d2, v);
    check("pre3_step", {24'd0, d2[7:0]}, {24'd0, 8'(d[7:0] + 8'd4)});
    repeat (1024) @(negedge clk);
    count_low(1024, lr, lg, lb);
    check("pre3_period_r", lr, 32'h21 * 4);

    // Byte-masked store and same-cycle load+store
    wr(A_CTRL, 32'h0, 4'hF);
    wr(A_DUTY, 32'h0011_2233, 4'hF);
    bus_addr = A_DUTY; bus_wdata = 32'h0000_AA00; bus_wmask = 4'b0010;
    bus_we = 1'b1; bus_re = 1'b1;
    @(negedge clk);
    v = bus_rvalid; d = bus_rdata; bus_we = 1'b0; bus_re = 1'b0;
    check("rw_same_valid", {31'd0, v}, 32'h1);
    check("rw_same_old", d, 32'h0011_2233);
    @(negedge clk);
    check("rdata_idle_zero", bus_rdata, 32'h0);
    rd(A_DUTY, d, v); check("masked_store", d, 32'h0011_AA33);

    // Reserved and out-of-range accesses
    wr(A_RSVD, 32'hFFFF_FFFF, 4'hF);
    wr(BASE + 32'h10, 32'hFFFF_FFFF, 4'hF);
    rd(A_RSVD, d, v);
    check("rsvd_valid", {31'd0, v}, 32'h1);
    check("rsvd_data", d, 32'h0);
    rd(BASE + 32'h10, d, v);
    check("oor_no_valid", {31'd0, v}, 32'h0);
    check("oor_data", d, 32'h0);
    rd(A_DUTY, d, v); check("oor_store_ignored", d, 32'h0011_AA33);

    // Randomized masked register traffic vs register model
    for (int i = 0; i < 3; i++) m_duty[i] = 8'h00;
    m_duty[0] = 8'h33; m_duty[1] = 8'hAA; m_duty[2] = 8'h11;
    m_en = 1'b0; m_led = 1'b0; m_pre = 8'h00;
    for (int it = 0; it < 16; it++) begin
      a  = ($urandom_range(0, 1) == 0) ? A_DUTY : A_CTRL;
      a  = a | 32'($urandom_range(0, 3));
      wd = $urandom;
      m  = 4'($urandom_range(0, 15));
      wr(a, wd, m); model_wr(a & ~32'h3, wd, m);
      rd(A_DUTY, d, v); check("rnd_duty", d, model_duty());
      rd(A_CTRL, d, v); check("rnd_ctrl", d, model_ctrl());
      check("rnd_led_pin", {31'd0, LED}, {31'd0, m_led});
    end

    // Reset mid-period with a load in flight
    wr(A_DUTY, 32'h00FF_FFFF, 4'hF);
    wr(A_CTRL, 32'h0000_0003, 4'hF);
    repeat (300) @(negedge clk);
    check("pre_rst_led", {31'd0, LED}, 32'h1);
    bus_addr = A_DUTY; bus_re = 1'b1;
    @(posedge clk); #1;
    check("pre_rst_rvalid", {31'd0, bus_rvalid}, 32'h1);
    rst_n = 1'b0; bus_re = 1'b0;
    #1;
    check("arst_pins", {29'd0, RGB_R, RGB_G, RGB_B}, 32'h7);
    check("arst_led", {31'd0, LED}, 32'h0);
    check("arst_rvalid", {31'd0, bus_rvalid}, 32'h0);
    check("arst_rdata", bus_rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_no_rvalid", {31'd0, bus_rvalid}, 32'h0);
    rd(A_DUTY, d, v); check("post_rst_duty", d, 32'h0);
    rd(A_CTRL, d, v); check("post_rst_ctrl", d, 32'h0);
    rd(A_STAT, d, v); check("post_rst_status", d, 32'h0);
    check("post_rst_pins", {29'd0, RGB_R, RGB_G, RGB_B}, 32'h7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
